// File: rtl/rescale_neighbor_fetch.sv
// rescale_neighbor_fetch
//
// Input-side row window for the rescale core. Source pixels arrive on an AXI-Stream,
// are packed to RGB565 and stored in two line buffers (TOP and BOT). The rescale datapath
// asks for the window to be advanced by one row, refilled with two fresh rows, or moved
// forward by discarding rows. Bilinear neighbor lookups are answered from the window.
//
// Optional feature: define RESCALE_FETCH_TLAST_CHECK_EN to enable the sticky tlast
// mismatch flag on `error`. When it is undefined, s_tlast is ignored and error is 0.
//
// Ports:
//   clock, reset         single posedge clock, asynchronous active-high reset
//   frame_start          pulse; starts (or restarts) the 2-row fill of a new frame
//   s_tdata/valid/last   source pixel stream {8'b0, R, G, B}
//   s_tready             stream ready (high in FILL and DISCARD)
//   in_stream_ready      row-advance request, rising edge is the request
//   skip, row_to_wait    request qualifiers sampled on the request edge
//   neighbor_offset      signed-ish column of the left neighbors
//   neighbor0..3         registered top[c], top[c+1], bot[c], bot[c+1]
//   rows_ready           window valid
//   frame_done           one-cycle pulse when the last source row has been consumed
//   error                sticky tlast mismatch flag (0 unless the check is enabled)

module rescale_neighbor_fetch #(
  parameter int unsigned SRC_COLS = 320,
  parameter int unsigned SRC_ROWS = 240
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_start,
  input  logic [31:0] s_tdata,
  input  logic        s_tvalid,
  input  logic        s_tlast,
  output logic        s_tready,
  input  logic        in_stream_ready,
  input  logic        skip,
  input  logic [8:0]  row_to_wait,
  input  logic [10:0] neighbor_offset,
  output logic [15:0] neighbor0,
  output logic [15:0] neighbor1,
  output logic [15:0] neighbor2,
  output logic [15:0] neighbor3,
  output logic        rows_ready,
  output logic        frame_done,
  output logic        error
);

  localparam int unsigned COL_W = 9;
  localparam int unsigned ROW_W = 8;

  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(SRC_COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(SRC_ROWS - 1);
  localparam logic [ROW_W-1:0] END_ROW   = ROW_W'(SRC_ROWS);
  localparam logic [10:0]      MAX_OFFS  = 11'(SRC_COLS - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FILL    = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;
  localparam logic [1:0] ST_READY   = 2'd3;

  logic [1:0]       state, state_next;
  logic [COL_W-1:0] col, col_next;
  logic [ROW_W-1:0] src_row, src_row_next;
  logic [1:0]       load_cnt, load_cnt_next;
  logic [8:0]       discard_cnt, discard_cnt_next;
  logic             swap, swap_next;
  logic             req_prev;
  logic             frame_done_next;

  logic             accept;
  logic             row_end;
  logic             req_edge;
  logic             exhausted;
  logic             final_row;
  logic [15:0]      pix;

  // Line buffers. With swap=0, TOP is line_a and BOT is line_b; swap=1 exchanges them.
  logic [15:0] line_a [SRC_COLS];
  logic [15:0] line_b [SRC_COLS];

  logic [COL_W-1:0] c_left;
  logic [COL_W-1:0] c_right;

  // --------------------------------------------------------------------------
  // Stream handshake and status decode
  // --------------------------------------------------------------------------
  assign s_tready   = (state == ST_FILL) || (state == ST_DISCARD);
  assign rows_ready = (state == ST_READY);

  assign accept    = s_tvalid && s_tready;
  assign row_end   = accept && (col == LAST_COL);
  assign req_edge  = in_stream_ready && !req_prev;
  assign exhausted = (src_row == END_ROW);
  assign final_row = (src_row == LAST_ROW);

  assign pix = {s_tdata[23:19], s_tdata[15:10], s_tdata[7:3]};

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next       = state;
    col_next         = col;
    src_row_next     = src_row;
    load_cnt_next    = load_cnt;
    discard_cnt_next = discard_cnt;
    swap_next        = swap;
    frame_done_next  = 1'b0;

    if (accept) begin
      col_next = (col == LAST_COL) ? '0 : col + 1'b1;
    end

    if (frame_start) begin
      // Restart from any state; a partially written row is simply overwritten.
      state_next    = ST_FILL;
      src_row_next  = '0;
      load_cnt_next = 2'd2;
      col_next      = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_next = ST_IDLE;
        end

        ST_FILL: begin
          if (row_end) begin
            // The row just written becomes BOT and the previous BOT becomes TOP.
            swap_next     = ~swap;
            src_row_next  = src_row + 1'b1;
            load_cnt_next = load_cnt - 2'd1;
            if (final_row) begin
              frame_done_next = 1'b1;
              load_cnt_next   = '0;
              state_next      = ST_READY;
            end else if (load_cnt == 2'd1) begin
              state_next = ST_READY;
            end
          end
        end

        ST_DISCARD: begin
          if (row_end) begin
            src_row_next     = src_row + 1'b1;
            discard_cnt_next = discard_cnt - 9'd1;
            if (final_row) begin
              // Out of source rows: keep the current window as the last one.
              frame_done_next  = 1'b1;
              discard_cnt_next = '0;
              state_next       = ST_READY;
            end else if (discard_cnt == 9'd1) begin
              load_cnt_next = 2'd2;
              state_next    = ST_FILL;
            end
          end
        end

        ST_READY: begin
          // After the last row a request leaves the window untouched.
          if (req_edge && !exhausted) begin
            if (!skip) begin
              load_cnt_next = 2'd1;
              state_next    = ST_FILL;
            end else if (row_to_wait == 9'd0) begin
              load_cnt_next = 2'd2;
              state_next    = ST_FILL;
            end else begin
              discard_cnt_next = row_to_wait;
              state_next       = ST_DISCARD;
            end
          end
        end

        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      col         <= '0;
      src_row     <= '0;
      load_cnt    <= '0;
      discard_cnt <= '0;
      swap        <= 1'b0;
      req_prev    <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_next;
      col         <= col_next;
      src_row     <= src_row_next;
      load_cnt    <= load_cnt_next;
      discard_cnt <= discard_cnt_next;
      swap        <= swap_next;
      req_prev    <= in_stream_ready;
      frame_done  <= frame_done_next;
    end
  end

  // --------------------------------------------------------------------------
  // Line buffer write
  // --------------------------------------------------------------------------
  // The incoming row goes into the stale TOP buffer, which the end-of-row swap turns
  // into the new BOT. This keeps TOP the older row without ever copying data.
  always_ff @(posedge clock) begin
    if (accept && (state == ST_FILL)) begin
      if (swap) begin
        line_b[col] <= pix;
      end else begin
        line_a[col] <= pix;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Neighbor lookup
  // --------------------------------------------------------------------------
  always_comb begin
    if (neighbor_offset[10]) begin
      c_left = '0;
    end else if (neighbor_offset > MAX_OFFS) begin
      c_left = LAST_COL;
    end else begin
      c_left = neighbor_offset[COL_W-1:0];
    end
    c_right = (c_left == LAST_COL) ? c_left : c_left + 1'b1;
  end

  // Lookups only refresh while the window is valid; otherwise the last answer is held.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      neighbor0 <= '0;
      neighbor1 <= '0;
      neighbor2 <= '0;
      neighbor3 <= '0;
    end else if (state == ST_READY) begin
      neighbor0 <= swap ? line_b[c_left]  : line_a[c_left];
      neighbor1 <= swap ? line_b[c_right] : line_a[c_right];
      neighbor2 <= swap ? line_a[c_left]  : line_b[c_left];
      neighbor3 <= swap ? line_a[c_right] : line_b[c_right];
    end
  end

  // --------------------------------------------------------------------------
  // tlast consistency check
  // --------------------------------------------------------------------------
`ifdef RESCALE_FETCH_TLAST_CHECK_EN
  logic error_flag;

  // Row boundaries are always taken from the column counter; tlast is only audited.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      error_flag <= 1'b0;
    end else if (accept && (s_tlast != (col == LAST_COL))) begin
      error_flag <= 1'b1;
    end
  end

  assign error = error_flag;
`else
  logic unused_tlast;

  assign unused_tlast = s_tlast;
  assign error        = 1'b0;
`endif

  // Bits dropped by the RGB888 to RGB565 packing.
  logic unused_tdata;

  assign unused_tdata = ^{s_tdata[31:24], s_tdata[18:16], s_tdata[9:8], s_tdata[2:0]};

endmodule

// File: tb/tb_rescale_neighbor_fetch.sv
// Bench for rescale_neighbor_fetch: directed stimulus, a row-level window model and a
// per-cycle compare process, plus literal checks taken from hand-computed values.
module tb_rescale_neighbor_fetch;

  localparam int COLS = 320;
  localparam int ROWS = 240;

`ifdef RESCALE_FETCH_TLAST_CHECK_EN
  localparam bit TLAST_EN = 1'b1;
`else
  localparam bit TLAST_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        frame_start = 1'b0;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_tready;
  logic        in_stream_ready = 1'b0;
  logic        skip = 1'b0;
  logic [8:0]  row_to_wait = '0;
  logic [10:0] neighbor_offset = '0;
  logic [15:0] neighbor0, neighbor1, neighbor2, neighbor3;
  logic        rows_ready;
  logic        frame_done;
  logic        error;

  rescale_neighbor_fetch #(
    .SRC_COLS(COLS),
    .SRC_ROWS(ROWS)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .frame_start    (frame_start),
    .s_tdata        (s_tdata),
    .s_tvalid       (s_tvalid),
    .s_tlast        (s_tlast),
    .s_tready       (s_tready),
    .in_stream_ready(in_stream_ready),
    .skip           (skip),
    .row_to_wait    (row_to_wait),
    .neighbor_offset(neighbor_offset),
    .neighbor0      (neighbor0),
    .neighbor1      (neighbor1),
    .neighbor2      (neighbor2),
    .neighbor3      (neighbor3),
    .rows_ready     (rows_ready),
    .frame_done     (frame_done),
    .error          (error)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: pixels of every source row sent, and which rows form the window.
  logic [15:0] exp_pix [ROWS*COLS];
  bit          model_ready = 1'b0;
  bit          model_tready = 1'b0;
  bit          exp_error = 1'b0;
  int          top_idx = 0;
  int          bot_idx = 0;
  logic [63:0] exp_n;
  int          acc_cnt = 0;
  int          fd_pulses = 0;
  int          base;

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [15:0] pack565(input logic [31:0] w);
    int r, g, b;
    r = int'(w[23:16]);
    g = int'(w[15:8]);
    b = int'(w[7:0]);
    return 16'((r / 8) * 2048 + (g / 4) * 32 + (b / 8));
  endfunction

  function automatic logic [31:0] gen(input int kind, input int row, input int col);
    case (kind)
      1:       return 32'h00F8FCF8;
      2:       return 32'h0;
      3:       return 32'h00F80000;
      4:       return {8'h00, 8'(col * 3), 8'(row + col), 8'(255 - col)};
      default: return {8'h00, 8'(row * 37 + col), 8'(col * 5 + row * 3), 8'(col ^ (row * 11))};
    endcase
  endfunction

  function automatic logic [63:0] lookup(input logic [10:0] off, input int t, input int b);
    int c, c1;
    if (off[10]) c = 0;
    else if (int'(off) > COLS - 1) c = COLS - 1;
    else c = int'(off);
    c1 = (c + 1 > COLS - 1) ? COLS - 1 : c + 1;
    return {exp_pix[t*COLS+c], exp_pix[t*COLS+c1], exp_pix[b*COLS+c], exp_pix[b*COLS+c1]};
  endfunction

  // Expected registered neighbor outputs: refreshed only while the model says valid.
  always @(posedge clock or posedge reset) begin
    if (reset) exp_n <= '0;
    else if (model_ready) exp_n <= lookup(neighbor_offset, top_idx, bot_idx);
  end

  always @(posedge clock) begin
    if (s_tvalid && s_tready) acc_cnt <= acc_cnt + 1;
    if (frame_done) fd_pulses <= fd_pulses + 1;
  end

  // Per-cycle compare against the model.
  always @(negedge clock) begin
    chk("rows_ready", {63'd0, rows_ready}, {63'd0, model_ready});
    chk("s_tready", {63'd0, s_tready}, {63'd0, model_tready});
    chk("neighbors", {neighbor0, neighbor1, neighbor2, neighbor3}, exp_n);
    chk("error", {63'd0, error}, {63'd0, exp_error});
  end

  initial begin
    #1500000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    finish_sim();
  end

  // Drive one beat from posedge+1 and return at posedge+1 after it was accepted.
  task automatic send_beat(input logic [31:0] w, input logic last);
    bit rdy;
    s_tvalid = 1'b1;
    s_tdata  = w;
    s_tlast  = last;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      rdy = s_tready;
      @(posedge clock);
      #1;
      if (rdy) return;
    end
    n_checks++;
    n_errors++;
    $display("FAIL beat_accept: s_tready got 0 expected 1 within 8 cycles at %0t", $time);
    finish_sim();
  endtask

  task automatic send_row(input int row, input int kind, input int bad_col, input bit stalls);
    for (int c = 0; c < COLS; c++) begin
      logic [31:0] w;
      w = gen(kind, row, c);
      if (stalls && (c % 53 == 7)) begin
        s_tvalid = 1'b0;
        @(posedge clock);
        #1;
      end
      exp_pix[row*COLS+c] = pack565(w);
      send_beat(w, (c == COLS - 1) ^ (c == bad_col));
      if (c == bad_col && TLAST_EN) exp_error = 1'b1;
    end
  endtask

  task automatic request(input bit sk, input logic [8:0] rtw);
    in_stream_ready = 1'b1;
    skip            = sk;
    row_to_wait     = rtw;
    @(posedge clock);
    #1;
    in_stream_ready = 1'b0;
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    @(posedge clock);
    #1;
    frame_start = 1'b0;
  endtask

  task automatic window_done(input int t, input int b);
    s_tvalid     = 1'b0;
    top_idx      = t;
    bot_idx      = b;
    model_ready  = 1'b1;
    model_tready = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    logic [10:0] offs [10];
    offs = '{11'd0, 11'd1, 11'd5, 11'd318, 11'd319, 11'd320, 11'd1023, 11'h7FF, 11'h400, 11'd177};

    #1 reset = 1'b1;
    #1;
    chk("reset_s_tready", {63'd0, s_tready}, 64'd0);
    chk("reset_rows_ready", {63'd0, rows_ready}, 64'd0);
    chk("reset_frame_done", {63'd0, frame_done}, 64'd0);
    chk("reset_neighbors", {neighbor0, neighbor1, neighbor2, neighbor3}, 64'd0);
    wait_cycles(3);
    reset = 1'b0;
    neighbor_offset = 11'd5;
    wait_cycles(2);

    // Initial fill: white row over black row.
    pulse_start();
    model_tready = 1'b1;
    chk("start_to_tready", {63'd0, s_tready}, 64'd1);
    send_row(0, 1, -1, 1'b1);
    send_row(1, 2, -1, 1'b1);
    window_done(0, 1);
    chk("fill_rows_ready", {63'd0, rows_ready}, 64'd1);
    wait_cycles(2);
    chk("fill_n0", {48'd0, neighbor0}, 64'hFFFF);
    chk("fill_n1", {48'd0, neighbor1}, 64'hFFFF);
    chk("fill_n2", {48'd0, neighbor2}, 64'h0);
    chk("fill_n3", {48'd0, neighbor3}, 64'h0);

    // Single advance with a red row.
    request(1'b0, 9'd0);
    model_ready  = 1'b0;
    model_tready = 1'b1;
    base = acc_cnt;
    send_row(2, 3, -1, 1'b1);
    window_done(1, 2);
    s_tvalid = 1'b1;
    wait_cycles(4);
    s_tvalid = 1'b0;
    chk("advance_beats", 64'(acc_cnt - base), 64'd320);
    chk("advance_n0", {48'd0, neighbor0}, 64'h0);
    chk("advance_n2", {48'd0, neighbor2}, 64'hF800);

    // Skip three rows, then load rows 6 and 7.
    request(1'b1, 9'd3);
    model_ready  = 1'b0;
    model_tready = 1'b1;
    base = acc_cnt;
    for (int r = 3; r < 8; r++) send_row(r, 0, -1, 1'b1);
    window_done(6, 7);
    chk("skip_beats", 64'(acc_cnt - base), 64'd1600);
    chk("skip_tready_low", {63'd0, s_tready}, 64'd0);

    foreach (offs[i]) begin
      neighbor_offset = offs[i];
      wait_cycles(2);
      if (offs[i] == 11'h7FF) begin
        chk("clamp_neg_left", {48'd0, neighbor0}, {48'd0, exp_pix[6*COLS+0]});
        chk("clamp_neg_right", {48'd0, neighbor1}, {48'd0, exp_pix[6*COLS+1]});
      end
      if (offs[i] == 11'd319) begin
        chk("clamp_edge_left", {48'd0, neighbor0}, {48'd0, exp_pix[6*COLS+319]});
        chk("clamp_edge_right", {48'd0, neighbor1}, {48'd0, exp_pix[6*COLS+319]});
      end
    end

    // Skip with zero rows to wait: fresh two-row load.
    request(1'b1, 9'd0);
    model_ready  = 1'b0;
    model_tready = 1'b1;
    send_row(8, 4, -1, 1'b1);
    send_row(9, 4, -1, 1'b0);
    window_done(8, 9);
    neighbor_offset = 11'd100;
    wait_cycles(3);

    // Discard past the end of the frame; the window must stay on rows 8/9.
    request(1'b1, 9'd300);
    model_ready  = 1'b0;
    model_tready = 1'b1;
    for (int r = 10; r < ROWS; r++) send_row(r, 2, -1, 1'b0);
    window_done(8, 9);
    chk("frame_done_high", {63'd0, frame_done}, 64'd1);
    wait_cycles(1);
    chk("frame_done_low", {63'd0, frame_done}, 64'd0);

    // Requests after the last row: no beats accepted, window stays valid.
    base = acc_cnt;
    s_tvalid = 1'b1;
    request(1'b0, 9'd0);
    wait_cycles(2);
    request(1'b1, 9'd4);
    wait_cycles(2);
    s_tvalid = 1'b0;
    chk("post_frame_beats", 64'(acc_cnt - base), 64'd0);
    chk("post_frame_ready", {63'd0, rows_ready}, 64'd1);
    chk("frame_done_pulses", 64'(fd_pulses), 64'd1);

    // New frame, abandoned after 100 beats by a second frame_start.
    pulse_start();
    model_ready  = 1'b0;
    model_tready = 1'b1;
    for (int c = 0; c < 100; c++) send_beat(gen(3, 0, c), 1'b0);
    s_tvalid = 1'b0;
    pulse_start();
    send_row(0, 4, 99, 1'b1);
    send_row(1, 0, -1, 1'b1);
    window_done(0, 1);
    neighbor_offset = 11'd42;
    wait_cycles(5);
    chk("tlast_error", {63'd0, error}, {63'd0, TLAST_EN});

    // Reset in the middle of a row.
    request(1'b0, 9'd0);
    model_ready  = 1'b0;
    model_tready = 1'b1;
    for (int c = 0; c < 150; c++) send_beat(gen(3, 2, c), 1'b0);
    reset        = 1'b1;
    s_tvalid     = 1'b0;
    model_ready  = 1'b0;
    model_tready = 1'b0;
    exp_error    = 1'b0;
    #1;
    chk("midrow_reset_tready", {63'd0, s_tready}, 64'd0);
    chk("midrow_reset_ready", {63'd0, rows_ready}, 64'd0);
    chk("midrow_reset_error", {63'd0, error}, 64'd0);
    chk("midrow_reset_nbrs", {neighbor0, neighbor1, neighbor2, neighbor3}, 64'd0);
    wait_cycles(2);
    reset = 1'b0;
    wait_cycles(3);

    // Fill again after reset: red over white.
    neighbor_offset = 11'd17;
    pulse_start();
    model_tready = 1'b1;
    send_row(0, 3, -1, 1'b0);
    send_row(1, 1, -1, 1'b0);
    window_done(0, 1);
    wait_cycles(2);
    chk("refill_n0", {48'd0, neighbor0}, 64'hF800);
    chk("refill_n3", {48'd0, neighbor3}, 64'hFFFF);
    wait_cycles(2);

    finish_sim();
  end

endmodule
